// File: rtl/crypto_frame_builder_pkg.sv
// Shared definitions for the crypto framing path. crypto_module and its bench
// import the same package.
package crypto_defs;
    localparam int          IN_WIDTH     = 32;
    localparam int          DATA_WIDTH   = 128;
    localparam logic [31:0] HDR_CTR_INIT = 32'h0000_0001;
    localparam int          KEY_WIDTH    = 128;
    localparam int          IV_WIDTH     = 96;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_HDR  = 2'd2,
        ST_PACK = 2'd3
    } state_t;
endpackage

// File: rtl/crypto_frame_builder_if.sv
// AXI-Stream style link used on both sides of the frame builder.
// A beat transfers on a rising edge where tvalid and tready are both 1; once
// tvalid is raised, tdata/tlast hold until that edge and tvalid never drops early.
interface crypto_frame_builder_if #(parameter int WIDTH = 32);
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [WIDTH-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/crypto_frame_builder_packer.sv
// Packs 32-bit words into 128-bit beats; a short final beat comes out
// right-aligned with the earliest word most significant.
module crypto_word_packer #(
    parameter int IN_WIDTH   = crypto_defs::IN_WIDTH,
    parameter int DATA_WIDTH = crypto_defs::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_en,
    input  logic [IN_WIDTH-1:0]   word,
    input  logic                  word_last,
    output logic                  beat_done,
    output logic [DATA_WIDTH-1:0] beat
);
    import crypto_defs::*;

    localparam int         ACC_WIDTH = DATA_WIDTH - IN_WIDTH;
    localparam logic [1:0] WCNT_LAST = 2'(DATA_WIDTH / IN_WIDTH - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic [1:0]           wcnt;

    // acc starts at zero, so shifting n words in leaves them right-aligned.
    assign beat      = {acc, word};
    assign beat_done = word_en && (word_last || (wcnt == WCNT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            wcnt <= '0;
        end else if (beat_done) begin
            acc  <= '0;
            wcnt <= '0;
        end else if (word_en) begin
            acc  <= beat[ACC_WIDTH-1:0];
            wcnt <= wcnt + 2'd1;
        end
    end
endmodule

// File: rtl/crypto_frame_builder.sv
// Frames a raw word stream for crypto_module: key beat, header beat
// {iv, counter}, then payload packed four words per beat with TLAST on the end.
module crypto_frame_builder #(
    parameter int          IN_WIDTH     = crypto_defs::IN_WIDTH,
    parameter int          DATA_WIDTH   = crypto_defs::DATA_WIDTH,
    parameter logic [31:0] HDR_CTR_INIT = crypto_defs::HDR_CTR_INIT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [crypto_defs::KEY_WIDTH-1:0]   key_in,
    input  logic [crypto_defs::IV_WIDTH-1:0]    iv_in,
    crypto_frame_builder_if.slave               s_axis,
    crypto_frame_builder_if.master              m_axis,
    output logic [15:0]                         pkt_count,
    output crypto_defs::state_t                 state_dbg
);
    import crypto_defs::*;

    state_t                state, state_next;
    logic                  out_valid, out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [KEY_WIDTH-1:0]  key_sh;
    logic [IV_WIDTH-1:0]   iv_sh;
    logic                  m_hs, s_ready, word_en, beat_done;
    logic [DATA_WIDTH-1:0] beat;

    assign m_hs          = out_valid && m_axis.tready;
    assign word_en       = s_ready && s_axis.tvalid;
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;
    assign state_dbg     = state;

    crypto_word_packer #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .word_en   (word_en),
        .word      (s_axis.tdata),
        .word_last (s_axis.tlast),
        .beat_done (beat_done),
        .beat      (beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            ST_IDLE: if (s_axis.tvalid) state_next = ST_KEY;
            ST_KEY:  if (m_hs) state_next = ST_HDR;
            ST_HDR:  if (m_hs) state_next = ST_PACK;
            ST_PACK: begin
                // No new word while a packed beat waits, so acc is never overrun.
                s_ready = !out_valid;
                if (m_hs && out_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            key_sh    <= '0;
            iv_sh     <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (s_axis.tvalid) begin
                    key_sh    <= key_in;
                    iv_sh     <= iv_in;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_data  <= key_in;
                end
                ST_KEY: out_data <= m_hs ? {iv_sh, HDR_CTR_INIT} : key_sh;
                ST_HDR: if (m_hs) out_valid <= 1'b0;
                ST_PACK: begin
                    if (m_hs) begin
                        out_valid <= 1'b0;
                        if (out_last) pkt_count <= pkt_count + 16'd1;
                    end
                    if (beat_done) begin
                        out_valid <= 1'b1;
                        out_data  <= beat;
                        out_last  <= s_axis.tlast;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_crypto_frame_builder.sv
// Self-checking bench for crypto_frame_builder: expected beats come from a
// packet-level model that packs word lists with plain arithmetic.
module tb_crypto_frame_builder;
    import crypto_defs::*;

    localparam logic [127:0] KEY1 = 128'hee84e19cda87a76291eaaf2054aef812;
    localparam logic [95:0]  IV1  = 96'h13360015f2cb949b8fb0013e;
    localparam logic [127:0] KEY2 = 128'ha3557da8c75e9dfde2ff0bd90d0156f8;
    localparam logic [95:0]  IV2  = 96'h21640040428fc96f2fd10ba7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key_in = '0;
    logic [95:0]  iv_in = '0;
    logic [15:0]  pkt_count;
    state_t       state_dbg;

    crypto_frame_builder_if #(.WIDTH(32))  s_if();
    crypto_frame_builder_if #(.WIDTH(128)) m_if();

    crypto_frame_builder dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .iv_in     (iv_in),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .pkt_count (pkt_count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    logic [128:0] exp_q[$];
    logic [128:0] obs_q[$];
    logic [31:0]  pkt_words[$];
    bit           bp_mode = 1'b0;
    int           stall_err = 0;
    bit           held_pending = 1'b0;
    logic [128:0] held_beat = '0;

    // Output monitor: picks tready for the coming edge, records each handshake
    // and checks that a stalled beat does not change.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst) begin
                held_pending = 1'b0;
            end else begin
                if (held_pending && (!m_if.tvalid || {m_if.tlast, m_if.tdata} !== held_beat))
                    stall_err++;
                if (m_if.tvalid && m_if.tready) obs_q.push_back({m_if.tlast, m_if.tdata});
                held_pending = m_if.tvalid && !m_if.tready;
                held_beat    = {m_if.tlast, m_if.tdata};
            end
        end
    end

    // Reference model: key beat, {iv, 1} header, then words grouped by four;
    // a short group is the words concatenated in order, zero-extended.
    task automatic build_expected(input logic [127:0] key, input logic [95:0] iv);
        int n;
        int i;
        n = pkt_words.size();
        i = 0;
        exp_q.push_back({1'b0, key});
        exp_q.push_back({1'b0, iv, 32'h0000_0001});
        while (i < n) begin
            int take;
            logic [127:0] b;
            take = (n - i >= 4) ? 4 : n - i;
            b = '0;
            for (int j = 0; j < take; j++) b = (b << 32) | 128'(pkt_words[i + j]);
            i += take;
            exp_q.push_back({(i == n), b});
        end
    endtask

    task automatic random_words(input int n);
        pkt_words.delete();
        for (int k = 0; k < n; k++) pkt_words.push_back($urandom());
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        stall_err = 0;
    endtask

    task automatic drive_words(input logic [127:0] key, input logic [95:0] iv, input bit with_last,
                               input bit scramble_key, output bit timed_out);
        int idx;
        int cyc;
        bit hs;
        idx = 0;
        cyc = 0;
        key_in = key;
        iv_in = iv;
        while (idx < pkt_words.size() && cyc < 4000) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = pkt_words[idx];
            s_if.tlast  = with_last && (idx == pkt_words.size() - 1);
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (scramble_key) begin
                    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                    iv_in  = {$urandom(), $urandom(), $urandom()};
                end
            end
            cyc++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        timed_out = (idx < pkt_words.size());
    endtask

    task automatic wait_beats(output bit timed_out);
        int cyc;
        cyc = 0;
        while (obs_q.size() < exp_q.size() && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        timed_out = (obs_q.size() < exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        @(negedge clk);
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_if.tvalid); end
        total++; if (m_if.tdata !== 128'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_if.tdata); end
        total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_if.tlast); end
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_if.tready); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d want=0", pkt_count); end
        total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_beat();
        bit to_d, to_w;
        apply_reset();
        pkt_words = '{32'h4df64bff, 32'h1fa11895, 32'haf337eb6, 32'h6b66e129};
        build_expected(KEY1, IV1);
        drive_words(KEY1, IV1, 1'b1, 1'b0, to_d);
        wait_beats(to_w);
        total++; if (to_d || to_w) begin bad++; $display("FAIL full_timeout got=%0d want=%0d beats", obs_q.size(), exp_q.size()); end
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL full_count got=%0d want=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 3) begin
            total++;
            if (obs_q[1] !== {1'b0, 128'h13360015f2cb949b8fb0013e00000001}) begin bad++; $display("FAIL full_hdr got=%h", obs_q[1]); end
            total++;
            if (obs_q[2] !== {1'b1, 128'h4df64bff1fa11895af337eb66b66e129}) begin bad++; $display("FAIL full_data got=%h", obs_q[2]); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL full_pkt_count got=%0d want=1", pkt_count); end
    endtask

    task automatic test_partial_tail();
        bit to_d, to_w;
        apply_reset();
        pkt_words = '{32'h4df64bff, 32'h1fa11895, 32'haf337eb6, 32'h6b66e129, 32'h0000001f, 32'hda3cf888};
        build_expected(KEY1, IV1);
        drive_words(KEY1, IV1, 1'b1, 1'b0, to_d);
        wait_beats(to_w);
        total++; if (to_d || to_w || obs_q.size() !== 4) begin bad++; $display("FAIL tail_count got=%0d want=4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL tail_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 4) begin
            total++;
            if (obs_q[2][128] !== 1'b0) begin bad++; $display("FAIL tail_first_last got=%b want=0", obs_q[2][128]); end
            total++;
            if (obs_q[3] !== {1'b1, 128'h0000001fda3cf888}) begin bad++; $display("FAIL tail_data got=%h", obs_q[3]); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL tail_pkt_count got=%0d want=1", pkt_count); end
    endtask

    task automatic test_backpressure();
        bit to_d, to_w, any_to;
        logic [127:0] k;
        logic [95:0] v;
        apply_reset();
        bp_mode = 1'b1;
        any_to = 1'b0;
        for (int p = 0; p < 6; p++) begin
            if (p == 0) pkt_words = '{32'h4df64bff, 32'h1fa11895, 32'haf337eb6, 32'h6b66e129, 32'h0000001f, 32'hda3cf888};
            else random_words($urandom_range(1, 11));
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            v = {$urandom(), $urandom(), $urandom()};
            if (p == 0) begin k = KEY1; v = IV1; end
            build_expected(k, v);
            drive_words(k, v, 1'b1, 1'b0, to_d);
            any_to |= to_d;
        end
        wait_beats(to_w);
        bp_mode = 1'b0;
        total++; if (any_to || to_w || obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0 changes", stall_err); end
        total++; if (pkt_count !== 16'd6) begin bad++; $display("FAIL bp_pkt_count got=%0d want=6", pkt_count); end
    endtask

    task automatic test_back_to_back();
        bit to_d1, to_d2, to_w;
        int first_len;
        apply_reset();
        random_words(7);
        build_expected(KEY1, IV1);
        first_len = exp_q.size();
        drive_words(KEY1, IV1, 1'b1, 1'b1, to_d1);
        random_words(5);
        build_expected(KEY2, IV2);
        drive_words(KEY2, IV2, 1'b1, 1'b0, to_d2);
        wait_beats(to_w);
        total++; if (to_d1 || to_d2 || to_w || obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() > first_len) begin
            total++;
            if (obs_q[first_len] !== {1'b0, KEY2}) begin bad++; $display("FAIL b2b_key2 got=%h want=%h", obs_q[first_len], KEY2); end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL b2b_pkt_count got=%0d want=2", pkt_count); end
    endtask

    task automatic test_single_word();
        bit to_d, to_w;
        apply_reset();
        pkt_words = '{32'hdeadbeef};
        build_expected(KEY2, IV2);
        drive_words(KEY2, IV2, 1'b1, 1'b0, to_d);
        wait_beats(to_w);
        total++; if (to_d || to_w || obs_q.size() !== 3) begin bad++; $display("FAIL single_count got=%0d want=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 3) begin
            total++;
            if (obs_q[2] !== {1'b1, 128'h000000000000000000000000deadbeef}) begin bad++; $display("FAIL single_data got=%h", obs_q[2]); end
        end
    endtask

    task automatic test_random_stream();
        bit to_d, to_w, any_to;
        logic [127:0] k;
        logic [95:0] v;
        apply_reset();
        any_to = 1'b0;
        for (int p = 0; p < 8; p++) begin
            random_words($urandom_range(1, 13));
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            v = {$urandom(), $urandom(), $urandom()};
            build_expected(k, v);
            drive_words(k, v, 1'b1, 1'b0, to_d);
            any_to |= to_d;
        end
        wait_beats(to_w);
        total++; if (any_to || to_w || obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (pkt_count !== 16'd8) begin bad++; $display("FAIL rand_pkt_count got=%0d want=8", pkt_count); end
    endtask

    task automatic test_reset_mid();
        bit to_d, to_w;
        apply_reset();
        random_words(2);
        drive_words(KEY1, IV1, 1'b0, 1'b0, to_d);
        total++; if (to_d) begin bad++; $display("FAIL mid_words got=timeout want=2 accepted"); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b want=0", m_if.tvalid); end
        total++; if (m_if.tdata !== 128'h0) begin bad++; $display("FAIL mid_tdata got=%h want=0", m_if.tdata); end
        total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL mid_tlast got=%b want=0", m_if.tlast); end
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL mid_tready got=%b want=0", s_if.tready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL mid_pkt_count got=%0d want=0", pkt_count); end
        random_words(3);
        build_expected(KEY2, IV2);
        drive_words(KEY2, IV2, 1'b1, 1'b0, to_d);
        wait_beats(to_w);
        total++; if (to_d || to_w || obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL mid_next_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_next_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL mid_next_pkt_count got=%0d want=1", pkt_count); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        test_reset();
        test_full_beat();
        test_partial_tail();
        test_backpressure();
        test_back_to_back();
        test_single_word();
        test_random_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crypto_frame_builder.md
# crypto_frame_builder

Upstream framing stage for `crypto_module`. Accepts a packet of 32-bit payload words on an AXI-Stream slave, plus a key and a 96-bit IV on side ports. Emits the 128-bit beat sequence `crypto_module` consumes: a key beat, a crypto-header beat, then the payload packed four words per beat, with TLAST on the final beat. Packet framing, header counter insertion and partial-beat packing are handled here, so software only streams raw words.

## Interface
Parameters:
- `IN_WIDTH`, default 32: input word width.
- `DATA_WIDTH`, default 128: output beat width; must equal 4×`IN_WIDTH`.
- `HDR_CTR_INIT`, default 32'h00000001: counter field placed in the header beat.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `key_in`, in, 128: key for the next packet; sampled at packet start.
- `iv_in`, in, 96: IV for the next packet; sampled at packet start.
- `S_AXIS_TREADY`, out, 1: ready to accept an input word.
- `S_AXIS_TDATA`, in, 32: payload word.
- `S_AXIS_TLAST`, in, 1: last word of the packet.
- `S_AXIS_TVALID`, in, 1: input word valid.
- `M_AXIS_TVALID`, out, 1: output beat valid.
- `M_AXIS_TDATA`, out, 128: output beat.
- `M_AXIS_TLAST`, out, 1: last beat of the packet.
- `M_AXIS_TREADY`, in, 1: downstream (`crypto_module`) ready.
- `pkt_count`, out, 16: count of completed packets; wraps 16'hFFFF→0.

## Operation
State machine: IDLE → KEY → HDR → PACK → IDLE.
- **IDLE**
  - `S_AXIS_TREADY`=0, `M_AXIS_TVALID`=0.
  - When `S_AXIS_TVALID`=1, latch `key_in`/`iv_in` into shadow registers and go to KEY. The word itself is not consumed.
- **KEY**
  - Output register holds the shadow key, `M_AXIS_TVALID`=1, `M_AXIS_TLAST`=0.
  - On handshake (`M_AXIS_TVALID`&`M_AXIS_TREADY`), go to HDR.
- **HDR**
  - Output holds `{iv_shadow, HDR_CTR_INIT}`, with the IV in [127:32].
  - On handshake, go to PACK.
- **PACK**
  - `S_AXIS_TREADY` = `!out_valid`.
  - Each accepted word shifts into accumulator `acc` (`acc <= {acc[95:0], word}`); 2-bit word counter `wcnt` increments.
  - On the 4th word, or on a word with TLAST: load the output register with the packed beat, set `out_last`=TLAST, clear `acc` and `wcnt`.
  - Packing order: the first word of a full beat lands in [127:96].
  - A partial final beat of n words (1–3) is right-aligned. Valid words occupy [32n−1:0], earliest word most significant; upper bits are 0.
  - On a handshake of the beat with `out_last`=1: increment `pkt_count` and go to IDLE.
- Shadow key/IV stay constant for the whole packet. Changes to `key_in`/`iv_in` mid-packet are ignored.
- A packet with a single TLAST word is legal and produces key, header, then one 1-word partial beat.
- Input TLAST is the only end-of-packet marker. There is no length limit.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; `acc`, `wcnt`, shadow registers 0.
  - `M_AXIS_TVALID`=0, `M_AXIS_TDATA`=0, `M_AXIS_TLAST`=0, `S_AXIS_TREADY`=0, `pkt_count`=0.
  - Any partial packet is discarded; no TLAST is emitted for it.
- All M_AXIS outputs are registered. Once `M_AXIS_TVALID`=1, TDATA and TLAST hold until the handshake.
- Latency:
  - Key beat valid 1 cycle after `S_AXIS_TVALID` is first seen in IDLE.
  - Header beat valid the cycle after the key handshake.
  - `S_AXIS_TREADY` rises the cycle after the header handshake.
  - A packed beat is valid the cycle after its 4th (or TLAST) word is accepted.
- Throughput: `S_AXIS_TREADY` is low while a beat is pending. With `M_AXIS_TREADY`=1 the steady state is 4 words per 5 cycles.
- Backpressure: with `M_AXIS_TREADY`=0 the block holds its output indefinitely; the accumulator is not overwritten.
- A TLAST word accepted when `wcnt`=3 yields a full 4-word beat with TLAST.

## Structure
- Shared package `crypto_defs`: `DATA_WIDTH`, `IN_WIDTH`, `HDR_CTR_INIT`, the FSM state encoding (IDLE=0, KEY=1, HDR=2, PACK=3), and the key/IV widths. `crypto_module` and its bench reuse the same package.
- One natural sub-module: `crypto_word_packer`, holding the accumulator, `wcnt`, and the right-aligned partial-beat formatting. The FSM and output register stay in the top level.

## Test plan
- **Single full beat.** key 128'hee84e19cda87a76291eaaf2054aef812; iv 96'h13360015f2cb949b8fb0013e; words 4df64bff, 1fa11895, af337eb6, 6b66e129 (last with TLAST). Required output: key beat; 128'h13360015f2cb949b8fb0013e00000001; 128'h4df64bff1fa11895af337eb66b66e129 with TLAST; `pkt_count`=1.
- **Partial tail.** Same header, then 4 words followed by 0000001f, da3cf888 (TLAST). Required: second data beat is 128'h0000001fda3cf888 with TLAST; the first data beat has no TLAST.
- **Backpressure.** `M_AXIS_TREADY` random 50%. Required: output beats identical to the no-stall run; TDATA stable while TVALID is high and TREADY is low; no word lost or duplicated.
- **Back-to-back packets with key change.** Packet 2 uses key a3557da8c75e9dfde2ff0bd90d0156f8 and iv 21640040428fc96f2fd10ba7; `key_in` changes mid-packet-1. Required: packet 1 beats carry the old key; packet 2 key beat is a3557da8…; `pkt_count`=2.
- **Single-word packet.** One word deadbeef with TLAST. Required: key beat, header beat, then 128'h000000000000000000000000deadbeef with TLAST.
- **Reset mid-packet.** Assert `rst` after 2 data words are accepted. Required: all outputs 0 asynchronously; after release the next packet starts with a key beat; `pkt_count`=0.
